// File: rtl/tdc_readout_sched.sv
// Round-robin readout scheduler: grants one TDC frame buffer at a time onto the SPI
// word stream, tags each word with its channel index and aborts stalled transfers.
module tdc_readout_sched #(
   parameter int NCH    = 2,
   parameter int WORD_W = 24,
   parameter int TO_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        ch_int,
   input  logic [3*NCH-1:0]      ch_onum,
   input  logic [WORD_W*NCH-1:0] ch_data,
   output logic [NCH-1:0]        ch_read_en,
   output logic [NCH-1:0]        ch_odstart,
   input  logic                  spi_odstart,
   output logic [WORD_W-1:0]     spi_data,
   output logic                  irq,
   output logic                  busy,
   input  logic [TO_W-1:0]       timeout_cfg,
   output logic                  err_to,
   input  logic                  err_clr
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

   state_t          state;
   logic [NCH-1:0]  grant;
   logic [1:0]      ptr;
   logic [2:0]      len;
   logic [2:0]      word_cnt;
   logic [TO_W-1:0] timer;

   logic            req_any;
   logic [1:0]      sel;
   logic [NCH-1:0]  sel_oh;
   logic [2:0]      sel_onum;
   int              best_d;

   // Smallest wrap-around distance from ptr+1 wins, so the last served channel goes last.
   always_comb begin
      req_any  = 1'b0;
      sel      = ptr;
      sel_oh   = '0;
      sel_onum = 3'd0;
      best_d   = NCH;
      for (int i = 0; i < NCH; i++) begin
         if (ch_int[i] && (((i + 2*NCH - 1 - int'(ptr)) % NCH) < best_d)) begin
            best_d    = (i + 2*NCH - 1 - int'(ptr)) % NCH;
            req_any   = 1'b1;
            sel       = 2'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_onum  = ch_onum[3*i +: 3];
         end
      end
   end

   assign ch_read_en = grant;

   // The low two bits of the buffer word are replaced by the channel tag.
   always_comb begin
      spi_data   = '0;
      ch_odstart = '0;
      if (state == XFER) begin
         ch_odstart = grant & {NCH{spi_odstart}};
         for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
               spi_data      = ch_data[WORD_W*i +: WORD_W];
               spi_data[1:0] = 2'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         ptr      <= 2'(NCH-1);
         len      <= 3'd1;
         word_cnt <= 3'd0;
         timer    <= '0;
         irq      <= 1'b0;
         busy     <= 1'b0;
         err_to   <= 1'b0;
      end else begin
         if (err_clr)
            err_to <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant    <= sel_oh;
                  ptr      <= sel;
                  len      <= (sel_onum == 3'd0) ? 3'd1 : sel_onum;
                  word_cnt <= 3'd0;
                  timer    <= '0;
                  irq      <= 1'b1;
                  busy     <= 1'b1;
                  state    <= XFER;
               end
            end
            XFER: begin
               // A consumed word takes precedence over a coincident timeout.
               if (spi_odstart) begin
                  timer <= '0;
                  if (word_cnt == len - 3'd1) begin
                     grant <= '0;
                     irq   <= 1'b0;
                     state <= DONE;
                  end else begin
                     word_cnt <= word_cnt + 3'd1;
                  end
               end else begin
                  if (timer != {TO_W{1'b1}})
                     timer <= timer + TO_ONE;
                  if ((timeout_cfg != '0) && (timer == timeout_cfg - TO_ONE)) begin
                     err_to <= 1'b1;
                     grant  <= '0;
                     irq    <= 1'b0;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               // Gap cycle lets the buffer's registered INT fall before re-arbitration.
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               irq   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
